// File: rtl/rf_wb_arbiter.sv
// ============================================================================
// Module      : rf_wb_arbiter
// Description : Shares the single register-file write port between the
//               in-order pipeline writeback (port A) and a buffered
//               long-latency result stream (port B). A starvation counter
//               bounds how long the port-B FIFO head can lose to port A. A
//               per-register busy scoreboard lets decode stall RAW/WAW
//               hazards on registers still owned by the long-latency unit.
// Config      : RF_WB_BYPASS_EN - when defined, adds byp_hit1/byp_hit2/
//               byp_data forwarding outputs and masks hz_rsN in the cycle a
//               port-B commit writes chk_rsN.
// Ports       : clk, rst_n (async active-low)
//               a_valid/a_rd/a_wdata -> a_stall     pipeline writeback
//               b_valid/b_rd/b_wdata -> b_ready     long-latency results
//               sb_set/sb_rd                        issue-time busy set
//               chk_rs1/chk_rs2/chk_rd -> hz_rs1/hz_rs2/hz_rd
//               rf_en/rf_rd/rf_wdata                register-file write port
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_wb_arbiter #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            a_valid,
  input  logic [4:0]      a_rd,
  input  logic [XLEN-1:0] a_wdata,
  output logic            a_stall,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic [4:0]      b_rd,
  input  logic [XLEN-1:0] b_wdata,
  input  logic            sb_set,
  input  logic [4:0]      sb_rd,
  input  logic [4:0]      chk_rs1,
  input  logic [4:0]      chk_rs2,
  input  logic [4:0]      chk_rd,
  output logic            hz_rs1,
  output logic            hz_rs2,
  output logic            hz_rd,
  output logic            rf_en,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_wdata
`ifdef RF_WB_BYPASS_EN
  ,
  output logic            byp_hit1,
  output logic            byp_hit2,
  output logic [XLEN-1:0] byp_data
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int WW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  // FIFO storage (data path only, no reset needed)
  logic [4:0]      r_rd_mem   [DEPTH];
  logic [XLEN-1:0] r_data_mem [DEPTH];

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_b_ready;
  logic [WW-1:0] r_wait;
  logic [31:0]   r_busy;

  logic            w_a_eff;
  logic            w_nonempty;
  logic            w_grant_a;
  logic            w_grant_b;
  logic            w_push;
  logic [4:0]      w_head_rd;
  logic [XLEN-1:0] w_head_data;
  logic [CW-1:0]   w_count_nxt;
  logic [31:0]     w_busy_nxt;

  // Gating with rst_n keeps the write port quiet while reset is asserted,
  // since port A is otherwise purely combinational. x0 writes are dropped.
  assign w_a_eff     = rst_n && a_valid && (a_rd != 5'd0);
  assign w_nonempty  = (r_count != '0);
  assign w_head_rd   = r_rd_mem[r_rd_ptr];
  assign w_head_data = r_data_mem[r_rd_ptr];

  assign w_grant_b = w_nonempty && (!w_a_eff || (r_wait == WW'(MAX_WAIT)));
  assign w_grant_a = w_a_eff && !w_grant_b;
  assign a_stall   = w_a_eff && w_grant_b;

  assign b_ready     = r_b_ready;
  assign w_push      = b_valid && r_b_ready;
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_grant_b);

  always_comb begin
    rf_en    = 1'b0;
    rf_rd    = 5'd0;
    rf_wdata = '0;
    if (w_grant_b) begin
      rf_en    = (w_head_rd != 5'd0);
      rf_rd    = w_head_rd;
      rf_wdata = w_head_data;
    end else if (w_grant_a) begin
      rf_en    = 1'b1;
      rf_rd    = a_rd;
      rf_wdata = a_wdata;
    end
  end

  // Clear first, then set, so a same-cycle set on the committing rd wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_grant_b) begin
      w_busy_nxt[w_head_rd] = 1'b0;
    end
    if (sb_set) begin
      w_busy_nxt[sb_rd] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd_mem[r_wr_ptr]   <= b_rd;
      r_data_mem[r_wr_ptr] <= b_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_b_ready <= 1'b0;
      r_wait    <= '0;
      r_busy    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_grant_b) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count   <= w_count_nxt;
      // Registered full flag: no push/pop pass-through when full.
      r_b_ready <= (w_count_nxt != CW'(DEPTH));
      if (!w_nonempty || w_grant_b) begin
        r_wait <= '0;
      end else if (r_wait != WW'(MAX_WAIT)) begin
        r_wait <= r_wait + WW'(1);
      end
      r_busy <= w_busy_nxt;
    end
  end

`ifdef RF_WB_BYPASS_EN
  logic w_commit_rs1;
  logic w_commit_rs2;

  assign w_commit_rs1 = w_grant_b && (w_head_rd == chk_rs1);
  assign w_commit_rs2 = w_grant_b && (w_head_rd == chk_rs2);
  assign hz_rs1       = r_busy[chk_rs1] && !w_commit_rs1;
  assign hz_rs2       = r_busy[chk_rs2] && !w_commit_rs2;
  assign byp_hit1     = rf_en && (rf_rd == chk_rs1);
  assign byp_hit2     = rf_en && (rf_rd == chk_rs2);
  assign byp_data     = rf_wdata;
`else
  assign hz_rs1 = r_busy[chk_rs1];
  assign hz_rs2 = r_busy[chk_rs2];
`endif
  assign hz_rd = r_busy[chk_rd];

endmodule

`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
// ============================================================================
// Module      : tb_rf_wb_arbiter
// Description : Directed self-checking bench for rf_wb_arbiter. Inputs change
//               on the falling edge; combinational outputs are checked 1 ns
//               later, well away from the rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rf_wb_arbiter;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic            a_valid;
  logic [4:0]      a_rd;
  logic [XLEN-1:0] a_wdata;
  logic            a_stall;
  logic            b_valid;
  logic            b_ready;
  logic [4:0]      b_rd;
  logic [XLEN-1:0] b_wdata;
  logic            sb_set;
  logic [4:0]      sb_rd;
  logic [4:0]      chk_rs1;
  logic [4:0]      chk_rs2;
  logic [4:0]      chk_rd;
  logic            hz_rs1;
  logic            hz_rs2;
  logic            hz_rd;
  logic            rf_en;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_wdata;
`ifdef RF_WB_BYPASS_EN
  logic            byp_hit1;
  logic            byp_hit2;
  logic [XLEN-1:0] byp_data;
`endif

  int checks;
  int failures;

  rf_wb_arbiter #(.XLEN(XLEN), .DEPTH(2), .MAX_WAIT(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_valid  (a_valid),
    .a_rd     (a_rd),
    .a_wdata  (a_wdata),
    .a_stall  (a_stall),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_rd     (b_rd),
    .b_wdata  (b_wdata),
    .sb_set   (sb_set),
    .sb_rd    (sb_rd),
    .chk_rs1  (chk_rs1),
    .chk_rs2  (chk_rs2),
    .chk_rd   (chk_rd),
    .hz_rs1   (hz_rs1),
    .hz_rs2   (hz_rs2),
    .hz_rd    (hz_rd),
    .rf_en    (rf_en),
    .rf_rd    (rf_rd),
    .rf_wdata (rf_wdata)
`ifdef RF_WB_BYPASS_EN
    ,
    .byp_hit1 (byp_hit1),
    .byp_hit2 (byp_hit2),
    .byp_data (byp_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge (inputs are then changed by the caller).
  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    a_valid  = 1'b1;  // request during reset must not reach the write port
    a_rd     = 5'd5;
    a_wdata  = 32'h1234_5678;
    b_valid  = 1'b0;
    b_rd     = 5'd0;
    b_wdata  = '0;
    sb_set   = 1'b0;
    sb_rd    = 5'd0;
    chk_rs1  = 5'd9;
    chk_rs2  = 5'd9;
    chk_rd   = 5'd9;

    // ---------------- reset state ----------------
    nxt(); nxt(); #1;
    chk("rst_rf_en",   32'(rf_en),   32'd0);
    chk("rst_a_stall", 32'(a_stall), 32'd0);
    chk("rst_b_ready", 32'(b_ready), 32'd0);
    chk("rst_hz",      {29'd0, hz_rs1, hz_rs2, hz_rd}, 32'd0);

    nxt();
    rst_n   = 1'b1;
    a_valid = 1'b0;
    nxt(); #1;
    chk("idle_rf_en",   32'(rf_en),   32'd0);
    chk("idle_b_ready", 32'(b_ready), 32'd1);
    chk("idle_hz",      {29'd0, hz_rs1, hz_rs2, hz_rd}, 32'd0);

    // ---------------- A only ----------------
    nxt();
    a_valid = 1'b1; a_rd = 5'd5; a_wdata = 32'hDEAD_BEEF;
    #1;
    chk("aonly_rf_en",    32'(rf_en),   32'd1);
    chk("aonly_rf_rd",    32'(rf_rd),   32'd5);
    chk("aonly_rf_wdata", rf_wdata,     32'hDEAD_BEEF);
    chk("aonly_a_stall",  32'(a_stall), 32'd0);

    // ---------------- starvation ----------------
    nxt();
    a_rd = 5'd3; a_wdata = 32'hA0;
    b_valid = 1'b1; b_rd = 5'd7; b_wdata = 32'h11;
    #1;
    chk("starv_push_rf_rd", 32'(rf_rd), 32'd3);
    nxt();
    b_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("starv_a_rf_rd",   32'(rf_rd),   32'd3);
      chk("starv_a_a_stall", 32'(a_stall), 32'd0);
      nxt();
    end
    #1;
    chk("starv_b_a_stall",  32'(a_stall), 32'd1);
    chk("starv_b_rf_en",    32'(rf_en),   32'd1);
    chk("starv_b_rf_rd",    32'(rf_rd),   32'd7);
    chk("starv_b_rf_wdata", rf_wdata,     32'h11);
    nxt(); #1;
    chk("starv_after_rf_rd",   32'(rf_rd),   32'd3);
    chk("starv_after_a_stall", 32'(a_stall), 32'd0);

    // ---------------- full FIFO ----------------
    nxt();
    b_valid = 1'b1; b_rd = 5'd10; b_wdata = 32'h100;
    #1;
    chk("full_ready0", 32'(b_ready), 32'd1);
    nxt();
    b_rd = 5'd11; b_wdata = 32'h200;
    #1;
    chk("full_ready1", 32'(b_ready), 32'd1);
    nxt();
    b_rd = 5'd12; b_wdata = 32'h300;  // must be ignored
    #1;
    chk("full_ready_full", 32'(b_ready), 32'd0);
    chk("full_a_rf_rd",    32'(rf_rd),   32'd3);
    nxt();
    b_valid = 1'b0;
    #1;
    chk("full_wait2_rf_rd", 32'(rf_rd), 32'd3);
    nxt(); #1;
    chk("full_pop1_rf_rd",    32'(rf_rd),   32'd10);
    chk("full_pop1_rf_wdata", rf_wdata,     32'h100);
    chk("full_pop1_a_stall",  32'(a_stall), 32'd1);
    nxt(); #1;
    chk("full_after_ready", 32'(b_ready), 32'd1);
    chk("full_after_rf_rd", 32'(rf_rd),   32'd3);
    nxt();
    a_valid = 1'b0;
    #1;
    chk("full_pop2_rf_rd",    32'(rf_rd), 32'd11);
    chk("full_pop2_rf_wdata", rf_wdata,   32'h200);
    nxt(); #1;
    chk("full_empty_rf_en", 32'(rf_en), 32'd0);

    // ---------------- scoreboard ----------------
    nxt();
    sb_set = 1'b1; sb_rd = 5'd9;
    chk_rs1 = 5'd9; chk_rs2 = 5'd4; chk_rd = 5'd9;
    #1;
    chk("sb_not_yet", 32'(hz_rs1), 32'd0);
    nxt();
    sb_set = 1'b0;
    b_valid = 1'b1; b_rd = 5'd9; b_wdata = 32'h99;
    #1;
    chk("sb_set_rs1", 32'(hz_rs1), 32'd1);
    chk("sb_set_rs2", 32'(hz_rs2), 32'd0);
    chk("sb_set_rd",  32'(hz_rd),  32'd1);
    nxt();
    b_valid = 1'b0;
    #1;
    chk("sb_commit_rf_rd", 32'(rf_rd), 32'd9);
`ifdef RF_WB_BYPASS_EN
    chk("sb_commit_hz_rs1", 32'(hz_rs1), 32'd0);
    chk("sb_commit_byp",    32'(byp_hit1), 32'd1);
`else
    chk("sb_commit_hz_rs1", 32'(hz_rs1), 32'd1);
`endif
    nxt();
    b_valid = 1'b1; b_rd = 5'd9; b_wdata = 32'h77;
    sb_set = 1'b1; sb_rd = 5'd9;
    #1;
    chk("sb_cleared", 32'(hz_rs1), 32'd0);
    nxt();
    b_valid = 1'b0;  // pop of rd 9 coincides with a new set of rd 9
    #1;
    chk("sb_sc_rf_rd", 32'(rf_rd), 32'd9);
    nxt();
    sb_set = 1'b0;
    #1;
    chk("sb_set_wins", 32'(hz_rs1), 32'd1);
    nxt();
    sb_set = 1'b1; sb_rd = 5'd0; chk_rs2 = 5'd0;
    nxt();
    sb_set = 1'b0;
    #1;
    chk("sb_x0_never", 32'(hz_rs2), 32'd0);

    // ---------------- x0 handling ----------------
    nxt();
    b_valid = 1'b1; b_rd = 5'd13; b_wdata = 32'h55;
    nxt();
    a_valid = 1'b1; a_rd = 5'd0; a_wdata = 32'hFFFF_FFFF;
    b_rd = 5'd0; b_wdata = 32'h66;
    #1;
    chk("x0_b_rf_rd",    32'(rf_rd),   32'd13);
    chk("x0_b_rf_en",    32'(rf_en),   32'd1);
    chk("x0_no_stall",   32'(a_stall), 32'd0);
    nxt();
    b_valid = 1'b0;
    #1;
    chk("x0_head0_rf_en", 32'(rf_en),   32'd0);
    chk("x0_head0_stall", 32'(a_stall), 32'd0);
    nxt(); #1;
    chk("x0_empty_rf_en", 32'(rf_en), 32'd0);

    // ---------------- mid-stream reset ----------------
    nxt();
    a_valid = 1'b1; a_rd = 5'd3; a_wdata = 32'hA0;
    b_valid = 1'b1; b_rd = 5'd14; b_wdata = 32'hEE;
    sb_set = 1'b1; sb_rd = 5'd20; chk_rd = 5'd20;
    nxt();
    b_valid = 1'b0; sb_set = 1'b0;
    #1;
    chk("mid_busy_before", 32'(hz_rd), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_hz_rd",   32'(hz_rd),   32'd0);
    chk("mid_rst_hz_rs1",  32'(hz_rs1),  32'd0);
    chk("mid_rst_b_ready", 32'(b_ready), 32'd0);
    chk("mid_rst_rf_en",   32'(rf_en),   32'd0);
    nxt();
    rst_n = 1'b1; a_valid = 1'b0;
    nxt(); #1;
    chk("mid_post_rf_en",   32'(rf_en),   32'd0);
    chk("mid_post_b_ready", 32'(b_ready), 32'd1);
    chk("mid_post_hz_rs1",  32'(hz_rs1),  32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
